ysyx_24110006_ifu: RTL and testbench



---
 rtl/ysyx_24110006_pkg.sv | 14 +
 rtl/ysyx_24110006_perf_cnt.sv | 22 ++
 rtl/ysyx_24110006_ifu.sv | 154 +++++++++++++++
 tb/tb_ysyx_24110006_ifu.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110006_pkg.sv
// Shared types and constants for the ysyx_24110006 instruction fetch unit.
package ysyx_24110006_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HOLD = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24110006_perf_cnt.sv
// 32-bit wrapping event counter with increment enable.
module ysyx_24110006_perf_cnt (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_en,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    // Count enabled cycles; wraps naturally at 2^32.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ysyx_24110006_ifu.sv
// Instruction fetch unit: one outstanding single-beat AXI4-Lite read per PC,
// result handed to decode over valid/ready; redirects kill the fetch in flight.
// Optional feature macro: IFU_PERF_EN (adds o_perf_fetch / o_perf_wait).
module ysyx_24110006_ifu
    import ysyx_24110006_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_pc,
    input  logic        i_pc_valid,
    output logic        o_pc_ready,
    input  logic        i_flush,
    output logic [31:0] o_araddr,
    output logic        o_arvalid,
    input  logic        i_arready,
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_rresp,
    input  logic        i_rvalid,
    output logic        o_rready,
`ifdef IFU_PERF_EN
    output logic [31:0] o_perf_fetch,
    output logic [31:0] o_perf_wait,
`endif
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_fault,
    output logic        o_valid,
    input  logic        i_ready
);

    ifu_state_e  r_state;
    ifu_state_e  w_next_state;

    logic        r_kill;
    logic [31:0] r_araddr;
    logic        r_arvalid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_fault;
    logic        r_valid;

    logic        w_pc_accept;
    logic        w_r_hs;
    logic        w_r_keep;
    logic        w_out_valid;

    // A response is kept only if no flush arrived earlier or in the same cycle.
    assign w_r_hs   = (r_state == S_DATA) && i_rvalid;
    assign w_r_keep = w_r_hs && !r_kill && !i_flush;

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and combinational handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_pc_accept  = 1'b0;
        w_out_valid  = 1'b0;
        o_rready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pc_accept = i_reset_n && !i_flush && i_pc_valid;
                if (w_pc_accept) begin
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                if (i_arready) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                o_rready = 1'b1;
                if (i_rvalid) begin
                    w_next_state = w_r_keep ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                w_out_valid = r_valid && !i_flush;
                if (i_flush || (w_out_valid && i_ready)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign o_pc_ready = i_reset_n && (r_state == S_IDLE) && !i_flush;
    assign o_valid    = w_out_valid;

    // Registered AXI address channel, kill flag and instruction output.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_kill    <= 1'b0;
            r_inst    <= '0;
            r_inst_pc <= RESET_PC;
            r_fault   <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            if (w_pc_accept) begin
                r_araddr <= i_pc;
            end
            // arvalid mirrors ADDR residency, so a flush never retracts it early.
            r_arvalid <= (w_next_state == S_ADDR);
            if (w_next_state == S_IDLE) begin
                r_kill <= 1'b0;
            end else if (i_flush && ((r_state == S_ADDR) || (r_state == S_DATA))) begin
                r_kill <= 1'b1;
            end
            if (w_r_keep) begin
                r_inst    <= i_rdata;
                r_inst_pc <= r_araddr;
                r_fault   <= (i_rresp != AXI_RESP_OKAY);
            end
            r_valid <= (w_next_state == S_HOLD);
        end
    end

    assign o_araddr  = r_araddr;
    assign o_arvalid = r_arvalid;
    assign o_inst    = r_inst;
    assign o_inst_pc = r_inst_pc;
    assign o_fault   = r_fault;

`ifdef IFU_PERF_EN
    logic w_wait_cycle;
    assign w_wait_cycle = (r_state == S_ADDR) || (r_state == S_DATA);

    ysyx_24110006_perf_cnt u_perf_fetch (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_en      (w_r_keep),
        .o_count   (o_perf_fetch)
    );

    ysyx_24110006_perf_cnt u_perf_wait (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_en      (w_wait_cycle),
        .o_count   (o_perf_wait)
    );
`endif

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// Directed self-checking bench for ysyx_24110006_ifu.
`timescale 1ns/1ps
module tb_ysyx_24110006_ifu;

    logic        i_clock = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_pc;
    logic        i_pc_valid;
    logic        o_pc_ready;
    logic        i_flush;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_fault;
    logic        o_valid;
    logic        i_ready;
`ifdef IFU_PERF_EN
    logic [31:0] o_perf_fetch;
    logic [31:0] o_perf_wait;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ysyx_24110006_ifu #(.RESET_PC(32'h8000_0000)) u_dut (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_pc       (i_pc),
        .i_pc_valid (i_pc_valid),
        .o_pc_ready (o_pc_ready),
        .i_flush    (i_flush),
        .o_araddr   (o_araddr),
        .o_arvalid  (o_arvalid),
        .i_arready  (i_arready),
        .i_rdata    (i_rdata),
        .i_rresp    (i_rresp),
        .i_rvalid   (i_rvalid),
        .o_rready   (o_rready),
`ifdef IFU_PERF_EN
        .o_perf_fetch (o_perf_fetch),
        .o_perf_wait  (o_perf_wait),
`endif
        .o_inst     (o_inst),
        .o_inst_pc  (o_inst_pc),
        .o_fault    (o_fault),
        .o_valid    (o_valid),
        .i_ready    (i_ready)
    );

    always #5 i_clock = ~i_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".arvalid"},  {31'd0, o_arvalid},  32'd0);
        check_eq({tag, ".rready"},   {31'd0, o_rready},   32'd0);
        check_eq({tag, ".valid"},    {31'd0, o_valid},    32'd0);
        check_eq({tag, ".fault"},    {31'd0, o_fault},    32'd0);
        check_eq({tag, ".pc_ready"}, {31'd0, o_pc_ready}, 32'd0);
        check_eq({tag, ".inst"},     o_inst,              32'h0);
        check_eq({tag, ".inst_pc"},  o_inst_pc,           32'h8000_0000);
        check_eq({tag, ".araddr"},   o_araddr,            32'h0);
    endtask

    // Full fetch: arw AR stall cycles, rw R stall cycles, dw decode stall cycles.
    task automatic fetch(input logic [31:0] pc, input int arw, input int rw,
                         input logic [31:0] data, input logic [1:0] resp,
                         input logic exp_fault, input int dw);
        i_pc = pc; i_pc_valid = 1'b1;
        #1 check_eq("idle.pc_ready", {31'd0, o_pc_ready}, 32'd1);
        cyc();
        i_pc_valid = 1'b0; i_pc = 32'hDEAD_BEEF;
        i_arready = 1'b0;
        for (int i = 0; i < arw; i++) begin
            #1;
            check_eq("addr.arvalid_wait", {31'd0, o_arvalid}, 32'd1);
            check_eq("addr.araddr_wait",  o_araddr, pc);
            check_eq("addr.pc_ready",     {31'd0, o_pc_ready}, 32'd0);
            cyc();
        end
        i_arready = 1'b1;
        #1;
        check_eq("addr.arvalid", {31'd0, o_arvalid}, 32'd1);
        check_eq("addr.araddr",  o_araddr, pc);
        cyc();
        i_arready = 1'b0;
        for (int i = 0; i < rw; i++) begin
            #1;
            check_eq("data.rready_wait", {31'd0, o_rready},  32'd1);
            check_eq("data.arvalid",     {31'd0, o_arvalid}, 32'd0);
            cyc();
        end
        i_rvalid = 1'b1; i_rdata = data; i_rresp = resp;
        #1 check_eq("data.rready", {31'd0, o_rready}, 32'd1);
        cyc();
        i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;
        i_ready = 1'b0;
        for (int i = 0; i < dw; i++) begin
            #1;
            check_eq("hold.valid_wait",   {31'd0, o_valid}, 32'd1);
            check_eq("hold.inst_wait",    o_inst, data);
            check_eq("hold.pc_ready",     {31'd0, o_pc_ready}, 32'd0);
            cyc();
        end
        i_ready = 1'b1;
        #1;
        check_eq("hold.valid",   {31'd0, o_valid}, 32'd1);
        check_eq("hold.inst",    o_inst, data);
        check_eq("hold.inst_pc", o_inst_pc, pc);
        check_eq("hold.fault",   {31'd0, o_fault}, {31'd0, exp_fault});
        cyc();
        i_ready = 1'b0;
        #1;
        check_eq("done.valid",    {31'd0, o_valid},    32'd0);
        check_eq("done.pc_ready", {31'd0, o_pc_ready}, 32'd1);
    endtask

    // Drive a fetch up to the first DATA cycle with zero-wait AR.
    task automatic start_to_data(input logic [31:0] pc);
        i_pc = pc; i_pc_valid = 1'b1;
        cyc();
        i_pc_valid = 1'b0; i_arready = 1'b1;
        cyc();
        i_arready = 1'b0;
    endtask

    initial begin
        i_reset_n = 1'b0; i_pc = '0; i_pc_valid = 1'b0; i_flush = 1'b0;
        i_arready = 1'b0; i_rdata = '0; i_rresp = '0; i_rvalid = 1'b0; i_ready = 1'b0;
        cyc(); cyc();
        check_reset_outputs("rst");
        i_reset_n = 1'b1;
        cyc();

        // Zero-wait fetch, then backpressure on AR and decode.
        fetch(32'h8000_0000, 0, 0, 32'h0000_0413, 2'b00, 1'b0, 0);
        fetch(32'h8000_0004, 5, 0, 32'h0010_0093, 2'b00, 1'b0, 4);

        // Flush while idle: PC refused, nothing issued.
        i_pc = 32'h8000_0100; i_pc_valid = 1'b1; i_flush = 1'b1;
        #1 check_eq("idleflush.pc_ready", {31'd0, o_pc_ready}, 32'd0);
        cyc();
        i_pc_valid = 1'b0; i_flush = 1'b0;
        #1 check_eq("idleflush.arvalid", {31'd0, o_arvalid}, 32'd0);

        // Flush in ADDR with AR stalled.
        i_pc = 32'h8000_0008; i_pc_valid = 1'b1;
        cyc();
        i_pc_valid = 1'b0; i_flush = 1'b1;
        #1 check_eq("faddr.arvalid0", {31'd0, o_arvalid}, 32'd1);
        cyc();
        i_flush = 1'b0;
        #1 check_eq("faddr.arvalid1", {31'd0, o_arvalid}, 32'd1);
        check_eq("faddr.araddr", o_araddr, 32'h8000_0008);
        i_arready = 1'b1;
        cyc();
        i_arready = 1'b0; i_rvalid = 1'b1; i_rdata = 32'h1111_1111;
        #1 check_eq("faddr.rready", {31'd0, o_rready}, 32'd1);
        cyc();
        i_rvalid = 1'b0;
        #1 check_eq("faddr.valid", {31'd0, o_valid}, 32'd0);
        check_eq("faddr.pc_ready", {31'd0, o_pc_ready}, 32'd1);

        // Flush together with the R handshake.
        start_to_data(32'h8000_000C);
        i_rvalid = 1'b1; i_rdata = 32'h2222_2222; i_flush = 1'b1;
        #1 check_eq("frdata.rready", {31'd0, o_rready}, 32'd1);
        cyc();
        i_rvalid = 1'b0; i_flush = 1'b0;
        #1 check_eq("frdata.valid", {31'd0, o_valid}, 32'd0);
        check_eq("frdata.pc_ready", {31'd0, o_pc_ready}, 32'd1);

        // Flush in HOLD while decode is ready.
        start_to_data(32'h8000_000C);
        i_rvalid = 1'b1; i_rdata = 32'h3333_3333;
        cyc();
        i_rvalid = 1'b0; i_flush = 1'b1; i_ready = 1'b1;
        #1 check_eq("fhold.valid", {31'd0, o_valid}, 32'd0);
        cyc();
        i_flush = 1'b0; i_ready = 1'b0;
        #1 check_eq("fhold.valid_after", {31'd0, o_valid}, 32'd0);
        check_eq("fhold.pc_ready", {31'd0, o_pc_ready}, 32'd1);

        fetch(32'h8000_0010, 0, 1, 32'h0000_8067, 2'b00, 1'b0, 0);

        // Error response.
        fetch(32'h8000_0014, 0, 0, 32'hCAFE_F00D, 2'b10, 1'b1, 1);

        // Reset while in DATA.
        start_to_data(32'h8000_0018);
        check_eq("rstdata.rready_before", {31'd0, o_rready}, 32'd1);
        i_reset_n = 1'b0;
        #1 check_reset_outputs("rstdata");
        cyc();
        i_reset_n = 1'b1;
        cyc();

        // Three fetches with two extra DATA wait cycles each.
        for (int k = 0; k < 3; k++) begin
            fetch(32'h8000_0020 + 32'(4 * k), 0, 2, 32'h0000_0013 + 32'(k), 2'b00, 1'b0, 0);
        end
`ifdef IFU_PERF_EN
        check_eq("perf.fetch", o_perf_fetch, 32'd3);
        check_eq("perf.wait",  o_perf_wait,  32'd12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
